// File: rtl/alu_result_stage.sv
// Two-entry in-order result buffer between the ALU result mux and writeback.
// Optional parity flag output enabled with `define ALU_PARITY_FLAG_EN.
module alu_result_stage (
  input  logic        Clock,
  input  logic        Reset,
  input  logic [23:0] resIn,
  input  logic [2:0]  cline,
  input  logic        carryIn,
  input  logic        ovfIn,
  input  logic        inValid,
  output logic        inReady,
  output logic [23:0] resOut,
  output logic [2:0]  opOut,
  output logic [3:0]  flagsOut,
  output logic        outValid,
  input  logic        outReady,
`ifdef ALU_PARITY_FLAG_EN
  output logic        flagP,
`endif
  output logic [1:0]  count
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  typedef struct packed {
    logic [23:0] res;
    logic [2:0]  op;
    logic [3:0]  flags;
`ifdef ALU_PARITY_FLAG_EN
    logic        par;
`endif
  } entry_t;

  state_t state, state_next;
  entry_t head, tail, in_entry;
  logic   push, pop;
  logic   arith;

  assign inReady  = (state != FULL);
  assign outValid = (state != EMPTY);
  assign push     = inValid & inReady;
  assign pop      = outValid & outReady;

  // C and V are only meaningful for ADD/SUB; logic/shift ops report them as 0.
  always_comb begin
    arith              = (cline == 3'b000) || (cline == 3'b001);
    in_entry           = '0;
    in_entry.res       = resIn;
    in_entry.op        = cline;
    in_entry.flags     = {resIn[23], (resIn == 24'd0), arith & carryIn, arith & ovfIn};
`ifdef ALU_PARITY_FLAG_EN
    in_entry.par       = ^resIn;
`endif
  end

  always_ff @(posedge Clock) begin
    if (Reset) state <= EMPTY;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      EMPTY: if (push) state_next = ONE;
      ONE: begin
        if (push && !pop)      state_next = FULL;
        else if (pop && !push) state_next = EMPTY;
      end
      FULL:    if (pop) state_next = ONE;
      default: state_next = EMPTY;
    endcase
  end

  // Simultaneous push/pop in ONE replaces the head directly; tail stays unused.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      head <= '0;
      tail <= '0;
    end else begin
      unique case (state)
        EMPTY: if (push) head <= in_entry;
        ONE: begin
          if (push && pop) head <= in_entry;
          else if (push)   tail <= in_entry;
          else if (pop)    head <= '0;
        end
        FULL: if (pop) begin
          head <= tail;
          tail <= '0;
        end
        default: begin
          head <= '0;
          tail <= '0;
        end
      endcase
    end
  end

  always_comb begin
    resOut   = outValid ? head.res   : '0;
    opOut    = outValid ? head.op    : '0;
    flagsOut = outValid ? head.flags : '0;
`ifdef ALU_PARITY_FLAG_EN
    flagP    = outValid ? head.par   : 1'b0;
`endif
    unique case (state)
      EMPTY:   count = 2'd0;
      ONE:     count = 2'd1;
      FULL:    count = 2'd2;
      default: count = 2'd0;
    endcase
  end

endmodule

// File: doc/alu_result_stage.md
ALU_RESULT_STAGE -- requirements
Module: alu_result_stage

Interface
REQ-001 SHALL have port Clock, input, 1, system clock; all state updates on its rising edge.
REQ-002 SHALL have port Reset, input, 1, synchronous active-high reset sampled on the rising edge of Clock.
REQ-003 SHALL have port resIn, input, 24, ALU result bus formed from the 24 per-bit 8:1 result-mux outputs.
REQ-004 SHALL have port cline, input, 3, op select that produced resIn (000=ADD, 001=SUB, 010-111 logic/shift ops).
REQ-005 SHALL have port carryIn, input, 1, adder carry-out accompanying resIn.
REQ-006 SHALL have port ovfIn, input, 1, adder signed overflow accompanying resIn.
REQ-007 SHALL have port inValid, input, 1, resIn/cline/carryIn/ovfIn valid this cycle.
REQ-008 SHALL have port inReady, output, 1, stage can accept an input this cycle.
REQ-009 SHALL have port resOut, output, 24, head-entry result.
REQ-010 SHALL have port opOut, output, 3, head-entry cline.
REQ-011 SHALL have port flagsOut, output, 4, head-entry flags {N,Z,C,V}.
REQ-012 SHALL have port outValid, output, 1, head entry valid.
REQ-013 SHALL have port outReady, input, 1, consumer (writeback/flag register) accepts head.
REQ-014 SHALL have port count, output, 2, current occupancy 0-2.

Function
REQ-015 SHALL be a 2-entry in-order buffer with FSM states EMPTY (count 0), ONE (count 1), FULL (count 2).
REQ-016 SHALL define push = inValid & inReady and pop = outValid & outReady.
REQ-017 SHALL drive inReady = (state != FULL) and outValid = (state != EMPTY), both decoded from registered state only.
REQ-018 SHALL transition EMPTY->ONE on push; ONE->FULL on push&~pop; ONE->EMPTY on pop&~push; FULL->ONE on pop; otherwise hold.
REQ-019 SHALL, in ONE with push&pop, keep state ONE and present the newly pushed entry as head next cycle.
REQ-020 SHALL never pass input combinationally to outputs; minimum latency push-to-outValid is 1 cycle.
REQ-021 SHALL compute flags at capture: Z = (resIn == 0); N = resIn[23]; C = carryIn and V = ovfIn when cline is 000 or 001, else C = 0 and V = 0.
REQ-022 SHALL, in FULL, ignore inValid (no push, no data overwrite) and preserve entry order.
REQ-023 SHALL hold resOut/opOut/flagsOut stable while outValid=1 and outReady=0.
REQ-024 SHALL drive resOut, opOut, flagsOut to zero whenever state is EMPTY.
REQ-025 SHALL treat X-free 0 on inValid during FULL/EMPTY transitions identically to any other cycle (no special cases beyond REQ-018).

Reset
REQ-026 SHALL, on Reset=1 at a rising Clock edge, enter EMPTY: count=0, outValid=0, inReady=1, resOut=0, opOut=0, flagsOut=0.
REQ-027 SHALL discard all buffered entries when Reset is asserted mid-operation, regardless of inValid/outReady that cycle.
REQ-028 SHALL give Reset priority over push and pop in the same cycle.

Configuration
REQ-029 SHALL, when macro ALU_PARITY_FLAG_EN is defined, add output flagP (1 bit) = even parity of head resOut (1 when number of ones is odd), captured at push, 0 in EMPTY and after reset.
REQ-030 SHALL, when ALU_PARITY_FLAG_EN is undefined, have no flagP port and otherwise identical behaviour.

Verification
REQ-031 SHALL cover: reset, then push resIn=24'h000000, cline=000, carryIn=1 -> next cycle outValid=1, flagsOut=4'b0110, count=1.
REQ-032 SHALL cover: push resIn=24'h800001, cline=011, carryIn=1, ovfIn=1 -> flagsOut=4'b1000 (C,V masked).
REQ-033 SHALL cover: outReady=0, push A=24'h000011 then B=24'h000022 -> count=2, inReady=0; third push C=24'h000033 ignored; pops yield 11 then 22.
REQ-034 SHALL cover: state ONE holding 24'h0000AA, same-cycle push 24'h0000BB and pop -> count stays 1, resOut=24'h0000BB next cycle.
REQ-035 SHALL cover: FULL with outReady=1 and Reset=1 same cycle -> next cycle count=0, outValid=0, resOut=0, inReady=1.
REQ-036 SHALL cover (ALU_PARITY_FLAG_EN defined): push resIn=24'h000007 -> flagP=1; push 24'h000003 -> flagP=0.
